// File: rtl/x_300_mod_997_seq_pkg.sv
// mod997_pkg: shared constants and types for the iterative 300-bit mod-997 reducer
package mod997_pkg;
  localparam int MOD = 997;
  localparam int CHUNK = 10;
  localparam int W = 300;
  localparam int NCHUNK = 30;
  localparam int K27 = 27;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [4:0] cnt_t;
endpackage

// File: rtl/x_300_mod_997_seq_if.sv
// x_300_mod_997_seq_if: operand and residue handshakes for the mod-997 reducer
interface x_300_mod_997_seq_if;
  import mod997_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [W-1:0] X;
  logic out_valid;
  logic out_ready;
  logic [9:0] R;
  logic busy;
  modport master(output in_valid, X, out_ready, input in_ready, out_valid, R, busy);
  modport slave(input in_valid, X, out_ready, output in_ready, out_valid, R, busy);
endinterface

// File: rtl/x_300_mod_997_seq_fold_step.sv
// mod997_fold_step: one Horner step, (acc*1024 + c) mod 997 for acc < 997
module mod997_fold_step
  import mod997_pkg::*;
(
  input  logic [9:0] acc,
  input  logic [9:0] c,
  output logic [9:0] acc_next
);
  logic [14:0] t;
  logic [10:0] u;
  logic [10:0] v;
  // 2^10 = 27 (mod 997), so each bit-10 overflow folds back as a multiple of 27
  assign t = 15'(acc) * 15'(K27) + 15'(c);
  assign u = 11'(t[9:0]) + 11'(t[14:10]) * 11'(K27);
  assign v = 11'(u[9:0]) + (u[10] ? 11'(K27) : 11'd0);
  assign acc_next = (v >= 11'(MOD)) ? 10'(v - 11'(MOD)) : v[9:0];
endmodule

// File: rtl/x_300_mod_997_seq.sv
// x_300_mod_997_seq: walks a 300-bit operand 10 bits per cycle, MSB first, to get X mod 997
module x_300_mod_997_seq
  import mod997_pkg::*;
(
  input logic clk,
  input logic rst,
  x_300_mod_997_seq_if.slave bus
);
  state_t state, state_n;
  cnt_t cnt;
  logic [9:0] acc, acc_next, r_q;
  logic [W-1:0] sr;
  mod997_fold_step u_fold (
    .acc(acc),
    .c(sr[W-1 -: CHUNK]),
    .acc_next(acc_next)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = bus.in_valid ? RUN : IDLE;
      RUN: state_n = (cnt == '0) ? DONE : RUN;
      DONE: state_n = bus.out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      sr <= '0;
      r_q <= '0;
    end else if (state == IDLE && bus.in_valid) begin
      sr <= bus.X;
      acc <= '0;
      cnt <= cnt_t'(NCHUNK - 1);
    end else if (state == RUN) begin
      acc <= acc_next;
      sr <= {sr[W-CHUNK-1:0], {CHUNK{1'b0}}};
      cnt <= cnt - cnt_t'(1);
      if (cnt == '0) r_q <= acc_next;
    end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.R = r_q;
endmodule

// File: tb/tb_x_300_mod_997_seq.sv
// tb_x_300_mod_997_seq: vector table, random operands and handshake corner cases against a bitwise mod-997 model
module tb_x_300_mod_997_seq;
  import mod997_pkg::*;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  x_300_mod_997_seq_if bus();
  x_300_mod_997_seq dut(.clk(clk), .rst(rst), .bus(bus));
  int total = 0;
  int bad = 0;
  logic [9:0] sb[$];
  typedef struct {
    logic [W-1:0] x;
    logic [9:0] r;
  } vec_t;
  vec_t vt[6];
  function automatic logic [9:0] gold(input logic [W-1:0] x);
    int r = 0;
    for (int i = W - 1; i >= 0; i--) r = (r * 2 + int'(x[i])) % MOD;
    return 10'(r);
  endfunction
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  // drives an operand until accepted; leaves in_valid high when hold is set
  task automatic accept(input logic [W-1:0] x, input logic [9:0] exp, input bit push, input bit hold);
    int n = 0;
    bus.X = x;
    bus.in_valid = 1;
    @(negedge clk);
    while (!bus.in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!hold) bus.in_valid = 0;
    if (push) sb.push_back(exp);
  endtask
  task automatic collect(input bit chk_lat);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 15) begin
        chk("in_ready_run", int'(bus.in_ready), 0);
        chk("busy_run", int'(bus.busy), 1);
      end
    end while (!bus.out_valid && n < 64);
    if (!bus.out_valid) begin
      chk("out_timeout", 0, 1);
      return;
    end
    if (chk_lat) chk("latency", n, 30);
    if (sb.size() == 0) chk("sb_empty", 0, 1);
    else chk("R", int'(bus.R), int'(sb.pop_front()));
    chk("R_range", int'(bus.R < 10'd997), 1);
    if (bus.out_ready) begin
      @(posedge clk);
      #1;
      chk("out_release", int'(bus.out_valid), 0);
    end
  endtask
  initial begin
    logic [W-1:0] x, y;
    logic [9:0] e;
    bus.in_valid = 0;
    bus.X = '0;
    bus.out_ready = 1;
    vt[0] = '{x: '0, r: 10'd0};
    vt[1] = '{x: 300'd996, r: 10'd996};
    vt[2] = '{x: 300'd997, r: 10'd0};
    vt[3] = '{x: 300'd1024, r: 10'd27};
    vt[4] = '{x: 300'd1 << 290, r: 10'd916};
    vt[5] = '{x: '1, r: gold('1)};
    #12;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_R", int'(bus.R), 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      accept(vt[i].x, vt[i].r, 1, 0);
      collect(1);
    end
    for (int k = 0; k < 1000; k++) begin
      for (int j = 0; j < 10; j++) x[j*30 +: 30] = 30'($urandom);
      accept(x, gold(x), 1, 0);
      collect(k < 4);
    end
    // backpressure: result must hold while the consumer stalls
    bus.out_ready = 0;
    x = {10{30'h2345_6789}};
    e = gold(x);
    accept(x, e, 1, 0);
    collect(1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", int'(bus.out_valid), 1);
      chk("bp_R", int'(bus.R), int'(e));
      chk("bp_in_ready", int'(bus.in_ready), 0);
    end
    bus.out_ready = 1;
    @(posedge clk);
    #1;
    chk("bp_release", int'(bus.out_valid), 0);
    chk("bp_idle", int'(bus.in_ready), 1);
    accept(300'd1024, 10'd27, 1, 0);
    chk("bp_next_accept", int'(bus.busy), 1);
    collect(1);
    // in_valid held high with a different operand during RUN
    x = {10{30'h1555_5555}};
    y = {10{30'h0F0F_0F0F}};
    accept(x, gold(x), 1, 1);
    bus.X = y;
    collect(1);
    chk("b2b_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    chk("b2b_accept", int'(bus.busy), 1);
    bus.in_valid = 0;
    sb.push_back(gold(y));
    collect(1);
    // reset mid-RUN abandons the operation
    accept(300'd1024, 10'd27, 1, 0);
    collect(1);
    accept('1, 10'd0, 0, 0);
    repeat (14) @(posedge clk);
    #1;
    rst = 1;
    #1;
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_in_ready", int'(bus.in_ready), 1);
    chk("mid_rst_R", int'(bus.R), 0);
    @(negedge clk);
    rst = 0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) chk("mid_rst_spurious", 1, 0);
    end
    accept(300'd1024, 10'd27, 1, 0);
    collect(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/x_300_mod_997_seq.md
# x_300_mod_997_seq

Iterative, area-reduced alternative to the fully combinational 300-bit mod-997 reducer. It accepts a 300-bit operand over a valid/ready handshake and walks it 10 bits per cycle, MSB chunk first, using Horner's rule with 2^10 mod 997 = 27. It returns a 10-bit residue in [0, 996] over a second valid/ready handshake. It sits wherever a mod-997 residue is needed at low throughput and one shared 15-bit fold datapath replaces the 30-term multiplier tree.

## Interface
- W, 300, operand width; only 300 is supported.
- CHUNK, 10, bits consumed per cycle; only 10 is supported.
- MOD, 997, modulus; only 997 is supported.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand X is valid.
- in_ready  out  1  block can accept an operand.
- X  in  300  operand, bit 1 = LSB.
- out_valid  out  1  R holds a finished residue.
- out_ready  in  1  consumer accepts R.
- R  out  10  X mod 997, always < 997 when out_valid=1.
- busy  out  1  high in RUN or DONE.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: 30 chunk steps.
  - DONE: out_valid=1.
- Accept: in_valid & in_ready at an edge. On accept:
  - latch X into a 300-bit shift register;
  - acc := 0, cnt := 29;
  - go to RUN.
- RUN step, one per cycle. Let c = top 10 bits of the shift register (chunk index cnt, where chunk k = X[10k+10:10k+1]).
  - t = acc*27 + c. acc < 997, so t ≤ 996*27 + 1023 = 27915, which fits in 15 bits.
  - Fold 1: u = t[10:1] + t[15:11]*27, so u ≤ 1752 (11 bits).
  - Fold 2: v = u[10:1] + u[11]*27, so v ≤ 1050.
  - Correct: acc := (v ≥ 997) ? v − 997 : v.
  - Shift the register left by 10 and decrement cnt.
- RUN exit: when the step with cnt = 0 completes, R := new acc and go to DONE.
- DONE: hold R and out_valid until out_ready=1. On that edge go to IDLE; out_valid falls.
- A new operand is never accepted in RUN or DONE; X is ignored there.
- in_valid may be held high across back-to-back operations.
- out_ready seen outside DONE has no effect.

## Timing
- Reset values (asynchronous):
  - state = IDLE, in_ready=1, out_valid=0, busy=0.
  - R = 0, acc = 0, cnt = 0, shift register = 0.
- Latency: accept at edge E0 → RUN steps at edges E1..E30 → out_valid=1 after E30. R is valid from the same edge.
- Throughput: one operand per 32 cycles with out_ready tied high. Sequence: E0 accept, E31 output handshake, E32 next accept.
- R and out_valid are registered; no combinational path from in_* to out_*.
- in_ready depends on state only; it is not a function of out_ready.
- Reset asserted mid-RUN or in DONE: the operation is abandoned. No out_valid is produced, and outputs take their reset values immediately.

## Structure
- Shared package `mod997_pkg`:
  - MOD = 997, CHUNK = 10, W = 300, NCHUNK = 30, K27 = 27 (2^10 mod 997);
  - state enum {IDLE, RUN, DONE};
  - 5-bit cnt type.
- Sub-module `mod997_fold_step`: purely combinational (acc[10], c[10]) → acc_next[10]. It contains the two folds and the conditional subtract. Exhaustive-testable standalone over acc < 997 and all c: 997 × 1024 cases, checked against a reference (acc*1024 + c) mod 997.
- Top module: FSM, counter, shift register, output register.

## Test plan
- X = 0 → after 30 RUN cycles, out_valid=1 and R = 0. in_ready is low from the accept until the output handshake.
- X = 996 → R = 996. X = 997 → R = 0. X = 1024 → R = 27.
- X with only bit 291 set (chunk 29 = 1) → R = 916. X = 2^300 − 1 and 1000 random operands → R matches the golden big-integer X mod 997.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → R and out_valid stay stable and in_ready stays 0. On the 6th cycle out_ready=1 → IDLE. The next operand is accepted the following cycle.
- in_valid held high with a new X during RUN → that X is ignored and the current result is unaffected.
- Assert rst at RUN step 15 → out_valid=0, in_ready=1, R=0 immediately. After reset is released, X = 1024 yields R = 27 with the normal 30-cycle latency.
